// File: rtl/gpout_write_arbiter_pkg.sv
// Shared constants, state encoding and helpers for the GP-output write arbiter.
package gpout_write_arbiter_pkg;

    localparam logic [3:0] GPOUT_ADDR_0   = 4'h0;
    localparam logic [3:0] GPOUT_ADDR_1   = 4'h1;
    localparam int         GPOUT_NUM_REGS = 2;
    localparam int         GAP_CNT_W      = 4;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_STROBE = 2'd1,
        ST_GAP    = 2'd2
    } gpout_state_e;

    // Index width that stays at least one bit wide for a single requester.
    function automatic int idx_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/gpout_write_arbiter_if.sv
// Requester-side handshake plus peripheral-side write port of the GP-output arbiter.
interface gpout_write_arbiter_if #(
    parameter int NREQ = 2,
    parameter int DW   = 16,
    parameter int AW   = 4
);
    import gpout_write_arbiter_pkg::*;

    localparam int IDW = idx_w(NREQ);

    logic [NREQ-1:0]    req_valid;
    logic [NREQ*AW-1:0] req_addr;
    logic [NREQ*DW-1:0] req_data;
    logic [NREQ-1:0]    req_ready;
    logic               cs;
    logic               wr;
    logic [AW-1:0]      addr;
    logic [DW-1:0]      d_out;
    logic [IDW-1:0]     gnt_id;
    logic               addr_err;
    logic               busy;

    modport master (
        output req_valid, req_addr, req_data,
        input  req_ready, cs, wr, addr, d_out, gnt_id, addr_err, busy
    );

    modport slave (
        input  req_valid, req_addr, req_data,
        output req_ready, cs, wr, addr, d_out, gnt_id, addr_err, busy
    );

endinterface

// File: rtl/gpout_write_arbiter_rr_pick.sv
// Combinational rotate-priority picker: first requester after last_grant wins.
module gpout_write_arbiter_rr_pick
    import gpout_write_arbiter_pkg::*;
#(
    parameter  int NREQ = 2,
    localparam int IDW  = idx_w(NREQ)
) (
    input  logic [NREQ-1:0] req,
    input  logic [IDW-1:0]  last,
    output logic [NREQ-1:0] gnt_oh,
    output logic [IDW-1:0]  gnt_idx,
    output logic            any
);

    int             cand;
    logic [IDW-1:0] cand_idx;

    always_comb begin
        gnt_oh   = '0;
        gnt_idx  = '0;
        any      = 1'b0;
        cand     = 0;
        cand_idx = '0;
        // Scan last+1, last+2, ... wrapping, so last_grant itself is checked last.
        for (int k = 1; k <= NREQ; k++) begin
            cand     = (int'(last) + k) % NREQ;
            cand_idx = IDW'(cand);
            if (!any && req[cand_idx]) begin
                any             = 1'b1;
                gnt_oh[cand_idx] = 1'b1;
                gnt_idx         = cand_idx;
            end
        end
    end

endmodule

// File: rtl/gpout_write_arbiter.sv
// Round-robin arbiter sharing the GP-output peripheral write port among NREQ requesters.
module gpout_write_arbiter
    import gpout_write_arbiter_pkg::*;
#(
    parameter int NREQ     = 2,
    parameter int DW       = 16,
    parameter int AW       = 4,
    parameter int NUM_REGS = GPOUT_NUM_REGS,
    parameter int WR_GAP   = 1
) (
    input  logic                  clk,
    input  logic                  rst,
    gpout_write_arbiter_if.slave  bus
);

    localparam int                   IDW        = idx_w(NREQ);
    localparam logic [GAP_CNT_W-1:0] GAP_LOAD   = GAP_CNT_W'((WR_GAP > 0) ? WR_GAP - 1 : 0);
    localparam logic [AW:0]          NUM_REGS_W = (AW+1)'(NUM_REGS);

    gpout_state_e         state_p1;
    gpout_state_e         state_nxt;
    logic [IDW-1:0]       last_grant_p1;
    logic [IDW-1:0]       gnt_id_p1;
    logic [AW-1:0]        addr_p1;
    logic [DW-1:0]        d_out_p1;
    logic [GAP_CNT_W-1:0] gap_cnt_p1;
    logic                 cs_p1;
    logic                 addr_err_p1;

    logic [NREQ-1:0]      win_oh;
    logic [IDW-1:0]       win_idx;
    logic                 win_any;
    logic [AW-1:0]        win_addr;
    logic [DW-1:0]        win_data;
    logic                 addr_ok;
    logic                 xfer;

    gpout_write_arbiter_rr_pick #(.NREQ(NREQ)) u_pick (
        .req     (bus.req_valid),
        .last    (last_grant_p1),
        .gnt_oh  (win_oh),
        .gnt_idx (win_idx),
        .any     (win_any)
    );

    always_comb begin
        win_addr = '0;
        win_data = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (win_oh[i]) begin
                win_addr = bus.req_addr[i*AW +: AW];
                win_data = bus.req_data[i*DW +: DW];
            end
        end
    end

    // Ready is held low while reset is asserted even though the state reads IDLE.
    assign addr_ok       = ({1'b0, win_addr} < NUM_REGS_W);
    assign xfer          = rst && (state_p1 == ST_IDLE) && win_any;
    assign bus.req_ready = xfer ? win_oh : '0;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_p1 <= ST_IDLE;
        end else begin
            state_p1 <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state_p1;
        unique case (state_p1)
            ST_IDLE: begin
                if (win_any) begin
                    if (addr_ok)         state_nxt = ST_STROBE;
                    else if (WR_GAP > 0) state_nxt = ST_GAP;
                    else                 state_nxt = ST_IDLE;
                end
            end
            ST_STROBE: begin
                if (WR_GAP > 0) state_nxt = ST_GAP;
                else            state_nxt = ST_IDLE;
            end
            ST_GAP: begin
                if (gap_cnt_p1 == '0) state_nxt = ST_IDLE;
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    // ---- output / bookkeeping register stage ----
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cs_p1         <= 1'b0;
            addr_err_p1   <= 1'b0;
            addr_p1       <= '0;
            d_out_p1      <= '0;
            gnt_id_p1     <= '0;
            last_grant_p1 <= IDW'(NREQ - 1);
            gap_cnt_p1    <= '0;
        end else begin
            cs_p1       <= (state_nxt == ST_STROBE);
            addr_err_p1 <= xfer && !addr_ok;
            if (xfer) begin
                gnt_id_p1     <= win_idx;
                last_grant_p1 <= win_idx;
                // A dropped write leaves the peripheral-facing addr/data untouched.
                if (addr_ok) begin
                    addr_p1  <= win_addr;
                    d_out_p1 <= win_data;
                end
            end
            if ((state_nxt == ST_GAP) && (state_p1 != ST_GAP)) begin
                gap_cnt_p1 <= GAP_LOAD;
            end else if (state_p1 == ST_GAP) begin
                gap_cnt_p1 <= gap_cnt_p1 - 1'b1;
            end
        end
    end

    assign bus.cs       = cs_p1;
    assign bus.wr       = cs_p1;
    assign bus.addr     = addr_p1;
    assign bus.d_out    = d_out_p1;
    assign bus.gnt_id   = gnt_id_p1;
    assign bus.addr_err = addr_err_p1;
    assign bus.busy     = (state_p1 != ST_IDLE);

endmodule

// File: tb/tb_gpout_write_arbiter.sv
// Self-checking bench for gpout_write_arbiter: directed scenarios plus a randomized run against a transaction-level model.
module tb_gpout_write_arbiter;
    import gpout_write_arbiter_pkg::*;

    localparam int NREQ  = 2;
    localparam int DW    = 16;
    localparam int AW    = 4;
    localparam int GAP_A = 1;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    gpout_write_arbiter_if #(.NREQ(NREQ), .DW(DW), .AW(AW)) bus_a ();
    gpout_write_arbiter_if #(.NREQ(NREQ), .DW(DW), .AW(AW)) bus_b ();

    gpout_write_arbiter #(.NREQ(NREQ), .DW(DW), .AW(AW), .NUM_REGS(2), .WR_GAP(GAP_A)) dut_a (
        .clk (clk),
        .rst (rst),
        .bus (bus_a.slave)
    );

    gpout_write_arbiter #(.NREQ(NREQ), .DW(DW), .AW(AW), .NUM_REGS(2), .WR_GAP(0)) dut_b (
        .clk (clk),
        .rst (rst),
        .bus (bus_b.slave)
    );

    // Peripheral stand-in for dut_a: samples the write port on the falling edge.
    logic [15:0] periph [2] = '{16'h0, 16'h0};
    always @(negedge clk) begin
        if (rst && bus_a.cs && bus_a.wr && (bus_a.addr < 4'd2)) periph[bus_a.addr[0]] <= bus_a.d_out;
    end

    task automatic set_req_a(input int i, input bit v, input logic [3:0] a, input logic [15:0] d);
        bus_a.req_valid[i]         = v;
        bus_a.req_addr[i*AW +: AW] = a;
        bus_a.req_data[i*DW +: DW] = d;
    endtask

    task automatic set_req_b(input int i, input bit v, input logic [3:0] a, input logic [15:0] d);
        bus_b.req_valid[i]         = v;
        bus_b.req_addr[i*AW +: AW] = a;
        bus_b.req_data[i*DW +: DW] = d;
    endtask

    task automatic apply_reset();
        rst = 1'b0;
        bus_a.req_valid = '0; bus_a.req_addr = '0; bus_a.req_data = '0;
        bus_b.req_valid = '0; bus_b.req_addr = '0; bus_b.req_data = '0;
        repeat (2) @(posedge clk);
        #1 rst = 1'b1;
    endtask

    task automatic test_reset();
        rst = 1'b0;
        bus_b.req_valid = '0; bus_b.req_addr = '0; bus_b.req_data = '0;
        set_req_a(0, 1'b1, GPOUT_ADDR_0, 16'h1111);
        set_req_a(1, 1'b1, GPOUT_ADDR_1, 16'h2222);
        repeat (2) @(posedge clk);
        @(negedge clk);
        checks++;
        if ({bus_a.cs, bus_a.wr, bus_a.addr_err, bus_a.busy} !== 4'b0000) begin
            failures++; $display("FAIL reset_ctrl got cs/wr/err/busy=%b want 0000", {bus_a.cs, bus_a.wr, bus_a.addr_err, bus_a.busy});
        end
        checks++;
        if (bus_a.addr !== 4'h0 || bus_a.d_out !== 16'h0 || bus_a.gnt_id !== 1'b0) begin
            failures++; $display("FAIL reset_data got addr=%h d_out=%h gnt=%0d want 0", bus_a.addr, bus_a.d_out, bus_a.gnt_id);
        end
        checks++;
        if (bus_a.req_ready !== 2'b00) begin
            failures++; $display("FAIL reset_ready got %b want 00", bus_a.req_ready);
        end
        @(posedge clk); #1 rst = 1'b1;
        @(negedge clk);
        checks++;
        if (bus_a.req_ready !== 2'b01) begin
            failures++; $display("FAIL reset_first_grant got %b want 01", bus_a.req_ready);
        end
        @(posedge clk); #1;
        set_req_a(0, 1'b0, 4'h0, 16'h0);
        set_req_a(1, 1'b0, 4'h0, 16'h0);
    endtask

    task automatic test_single_write();
        apply_reset();
        set_req_a(0, 1'b1, GPOUT_ADDR_0, 16'hA5A5);
        @(negedge clk);
        checks++;
        if (bus_a.req_ready !== 2'b01 || bus_a.busy !== 1'b0) begin
            failures++; $display("FAIL single_accept got ready=%b busy=%b want 01/0", bus_a.req_ready, bus_a.busy);
        end
        @(posedge clk); #1 set_req_a(0, 1'b0, 4'h0, 16'h0);
        @(negedge clk);
        checks++;
        if ({bus_a.cs, bus_a.wr, bus_a.busy} !== 3'b111 || bus_a.addr !== 4'h0 || bus_a.d_out !== 16'hA5A5 || bus_a.gnt_id !== 1'b0) begin
            failures++; $display("FAIL single_strobe got cs=%b wr=%b busy=%b addr=%h d=%h gnt=%0d want 1/1/1/0/a5a5/0",
                                 bus_a.cs, bus_a.wr, bus_a.busy, bus_a.addr, bus_a.d_out, bus_a.gnt_id);
        end
        set_req_a(1, 1'b1, GPOUT_ADDR_1, 16'h5A5A);
        @(negedge clk);
        checks++;
        if (bus_a.cs !== 1'b0 || bus_a.busy !== 1'b1 || bus_a.req_ready !== 2'b00 || bus_a.d_out !== 16'hA5A5) begin
            failures++; $display("FAIL single_gap got cs=%b busy=%b ready=%b d=%h want 0/1/00/a5a5", bus_a.cs, bus_a.busy, bus_a.req_ready, bus_a.d_out);
        end
        @(negedge clk);
        checks++;
        if (bus_a.busy !== 1'b0 || bus_a.req_ready !== 2'b10) begin
            failures++; $display("FAIL single_idle got busy=%b ready=%b want 0/10", bus_a.busy, bus_a.req_ready);
        end
        checks++;
        if (periph[0] !== 16'hA5A5) begin
            failures++; $display("FAIL single_periph got %h want a5a5", periph[0]);
        end
        @(posedge clk); #1 set_req_a(1, 1'b0, 4'h0, 16'h0);
    endtask

    task automatic test_contention();
        logic [15:0] nxt [2];
        logic [15:0] sent;
        logic [1:0]  exp_rdy;
        int          who;
        apply_reset();
        nxt[0] = 16'h1000; nxt[1] = 16'h2000; sent = '0;
        set_req_a(0, 1'b1, GPOUT_ADDR_0, nxt[0]);
        set_req_a(1, 1'b1, GPOUT_ADDR_1, nxt[1]);
        for (int k = 0; k < 12; k++) begin
            @(negedge clk);
            who     = (k / 3) % 2;
            exp_rdy = (k % 3 == 0) ? (2'b01 << who) : 2'b00;
            checks++;
            if (bus_a.req_ready !== exp_rdy) begin
                failures++; $display("FAIL contention_ready k=%0d got %b want %b", k, bus_a.req_ready, exp_rdy);
            end
            if (k % 3 == 1) begin
                checks++;
                if (bus_a.cs !== 1'b1 || bus_a.gnt_id !== 1'(who) || bus_a.d_out !== sent || bus_a.addr !== 4'(who)) begin
                    failures++; $display("FAIL contention_strobe k=%0d got cs=%b gnt=%0d d=%h addr=%h want 1/%0d/%h/%0d",
                                         k, bus_a.cs, bus_a.gnt_id, bus_a.d_out, bus_a.addr, who, sent, who);
                end
            end
            @(posedge clk); #1;
            if (exp_rdy != 2'b00) begin
                sent      = nxt[who];
                nxt[who]  = nxt[who] + 16'h1;
                set_req_a(who, 1'b1, 4'(who), nxt[who]);
            end
        end
        set_req_a(0, 1'b0, 4'h0, 16'h0);
        set_req_a(1, 1'b0, 4'h0, 16'h0);
        @(negedge clk);
        checks++;
        if (periph[0] !== 16'h1001 || periph[1] !== 16'h2001) begin
            failures++; $display("FAIL contention_periph got %h/%h want 1001/2001", periph[0], periph[1]);
        end
    endtask

    task automatic test_bad_address();
        logic [15:0] p0, p1;
        apply_reset();
        p0 = periph[0]; p1 = periph[1];
        set_req_a(1, 1'b1, 4'h5, 16'hDEAD);
        @(negedge clk);
        checks++;
        if (bus_a.req_ready !== 2'b10) begin
            failures++; $display("FAIL bad_accept got %b want 10", bus_a.req_ready);
        end
        @(posedge clk); #1 set_req_a(1, 1'b0, 4'h0, 16'h0);
        @(negedge clk);
        checks++;
        if ({bus_a.cs, bus_a.wr} !== 2'b00 || bus_a.addr_err !== 1'b1 || bus_a.gnt_id !== 1'b1 || bus_a.busy !== 1'b1 || bus_a.addr !== 4'h0) begin
            failures++; $display("FAIL bad_pulse got cs=%b wr=%b err=%b gnt=%0d busy=%b addr=%h want 0/0/1/1/1/0",
                                 bus_a.cs, bus_a.wr, bus_a.addr_err, bus_a.gnt_id, bus_a.busy, bus_a.addr);
        end
        @(negedge clk);
        checks++;
        if (bus_a.addr_err !== 1'b0 || bus_a.busy !== 1'b0 || bus_a.cs !== 1'b0) begin
            failures++; $display("FAIL bad_after got err=%b busy=%b cs=%b want 0/0/0", bus_a.addr_err, bus_a.busy, bus_a.cs);
        end
        checks++;
        if (periph[0] !== p0 || periph[1] !== p1) begin
            failures++; $display("FAIL bad_periph got %h/%h want %h/%h", periph[0], periph[1], p0, p1);
        end
    endtask

    task automatic test_gap0();
        logic [15:0] dat [4];
        int n;
        dat[0] = 16'h0101; dat[1] = 16'h0202; dat[2] = 16'h0303; dat[3] = 16'h0404;
        apply_reset();
        n = 0;
        set_req_b(0, 1'b1, 4'(n % 2), dat[n]);
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            if (k % 2 == 0) begin
                checks++;
                if (bus_b.req_ready !== 2'b01 || bus_b.cs !== 1'b0 || bus_b.busy !== 1'b0) begin
                    failures++; $display("FAIL gap0_accept k=%0d got ready=%b cs=%b busy=%b want 01/0/0", k, bus_b.req_ready, bus_b.cs, bus_b.busy);
                end
            end else begin
                checks++;
                if ({bus_b.cs, bus_b.wr, bus_b.busy} !== 3'b111 || bus_b.d_out !== dat[k/2] || bus_b.addr !== 4'((k/2) % 2) ||
                    bus_b.req_ready !== 2'b00 || bus_b.gnt_id !== 1'b0 || bus_b.addr_err !== 1'b0) begin
                    failures++; $display("FAIL gap0_strobe k=%0d got cs=%b wr=%b d=%h addr=%h ready=%b want 1/1/%h/%0d/00",
                                         k, bus_b.cs, bus_b.wr, bus_b.d_out, bus_b.addr, bus_b.req_ready, dat[k/2], (k/2) % 2);
                end
            end
            @(posedge clk); #1;
            if (k % 2 == 0) begin
                n++;
                if (n < 4) set_req_b(0, 1'b1, 4'(n % 2), dat[n]);
                else       set_req_b(0, 1'b0, 4'h0, 16'h0);
            end
        end
    endtask

    task automatic test_reset_during_strobe();
        logic [15:0] p1;
        apply_reset();
        p1 = periph[1];
        set_req_a(0, 1'b1, GPOUT_ADDR_1, 16'hBEEF);
        @(negedge clk);
        checks++;
        if (bus_a.req_ready !== 2'b01) begin
            failures++; $display("FAIL rststb_accept got %b want 01", bus_a.req_ready);
        end
        @(posedge clk); #1;
        set_req_a(0, 1'b0, 4'h0, 16'h0);
        set_req_a(1, 1'b1, GPOUT_ADDR_0, 16'h7777);
        #1;
        checks++;
        if (bus_a.cs !== 1'b1) begin
            failures++; $display("FAIL rststb_strobe got cs=%b want 1", bus_a.cs);
        end
        rst = 1'b0;
        #1;
        checks++;
        if ({bus_a.cs, bus_a.wr, bus_a.busy} !== 3'b000 || bus_a.req_ready !== 2'b00) begin
            failures++; $display("FAIL rststb_abort got cs=%b wr=%b busy=%b ready=%b want 0/0/0/00", bus_a.cs, bus_a.wr, bus_a.busy, bus_a.req_ready);
        end
        repeat (2) @(posedge clk);
        #1 rst = 1'b1;
        @(negedge clk);
        checks++;
        if (bus_a.req_ready !== 2'b10) begin
            failures++; $display("FAIL rststb_rearb got %b want 10", bus_a.req_ready);
        end
        @(posedge clk); #1 set_req_a(1, 1'b0, 4'h0, 16'h0);
        @(negedge clk);
        checks++;
        if (bus_a.cs !== 1'b1 || bus_a.d_out !== 16'h7777 || bus_a.addr !== 4'h0 || bus_a.gnt_id !== 1'b1) begin
            failures++; $display("FAIL rststb_after got cs=%b d=%h addr=%h gnt=%0d want 1/7777/0/1", bus_a.cs, bus_a.d_out, bus_a.addr, bus_a.gnt_id);
        end
        checks++;
        if (periph[1] !== p1) begin
            failures++; $display("FAIL rststb_periph got %h want %h", periph[1], p1);
        end
    endtask

    // Transaction-level model: a transfer at cycle c books the port until c+2+gap (good) or c+1+gap (dropped).
    task automatic test_random();
        int          free_at, last_g, cs_at, err_at, m_gnt, win, prob, cand;
        logic [3:0]  m_addr;
        logic [15:0] m_data;
        logic [1:0]  exp_rdy;
        bit          has [2];
        logic [3:0]  ra [2];
        logic [15:0] rd [2];
        apply_reset();
        free_at = 0; last_g = NREQ - 1; cs_at = -1; err_at = -1; m_gnt = 0; m_addr = '0; m_data = '0;
        has[0] = 1'b0; has[1] = 1'b0; ra[0] = '0; ra[1] = '0; rd[0] = '0; rd[1] = '0;
        for (int c = 0; c < 400; c++) begin
            if (c > 0) begin @(posedge clk); #1; end
            prob = (c < 200) ? 30 : 90;
            for (int i = 0; i < NREQ; i++) begin
                if (!has[i] && ($urandom_range(99) < prob)) begin
                    has[i] = 1'b1;
                    ra[i]  = ($urandom_range(7) == 0) ? 4'($urandom_range(15, 2)) : 4'($urandom_range(1));
                    rd[i]  = 16'($urandom);
                end
                set_req_a(i, has[i], ra[i], rd[i]);
            end
            @(negedge clk);
            checks++;
            if (bus_a.cs !== (c == cs_at) || bus_a.wr !== (c == cs_at)) begin
                failures++; $display("FAIL rand_cs c=%0d got cs=%b wr=%b want %b", c, bus_a.cs, bus_a.wr, (c == cs_at));
            end
            checks++;
            if (bus_a.addr_err !== (c == err_at)) begin
                failures++; $display("FAIL rand_err c=%0d got %b want %b", c, bus_a.addr_err, (c == err_at));
            end
            checks++;
            if (bus_a.busy !== (c < free_at)) begin
                failures++; $display("FAIL rand_busy c=%0d got %b want %b", c, bus_a.busy, (c < free_at));
            end
            checks++;
            if (bus_a.addr !== m_addr || bus_a.d_out !== m_data || bus_a.gnt_id !== 1'(m_gnt)) begin
                failures++; $display("FAIL rand_data c=%0d got addr=%h d=%h gnt=%0d want %h/%h/%0d", c, bus_a.addr, bus_a.d_out, bus_a.gnt_id, m_addr, m_data, m_gnt);
            end
            win = -1;
            if (c >= free_at) begin
                for (int s = 1; s <= NREQ; s++) begin
                    cand = (last_g + s) % NREQ;
                    if (win < 0 && has[cand]) win = cand;
                end
            end
            exp_rdy = (win < 0) ? 2'b00 : 2'(1 << win);
            checks++;
            if (bus_a.req_ready !== exp_rdy) begin
                failures++; $display("FAIL rand_ready c=%0d got %b want %b", c, bus_a.req_ready, exp_rdy);
            end
            if (win >= 0) begin
                last_g   = win;
                m_gnt    = win;
                has[win] = 1'b0;
                if (ra[win] < 4'd2) begin
                    cs_at   = c + 1;
                    m_addr  = ra[win];
                    m_data  = rd[win];
                    free_at = c + 2 + GAP_A;
                end else begin
                    err_at  = c + 1;
                    free_at = c + 1 + GAP_A;
                end
            end
        end
        @(posedge clk); #1;
        set_req_a(0, 1'b0, 4'h0, 16'h0);
        set_req_a(1, 1'b0, 4'h0, 16'h0);
    endtask

    initial begin
        test_reset();
        test_single_write();
        test_contention();
        test_bad_address();
        test_gap0();
        test_reset_during_strobe();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
